alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
Shares the single 32-bit combinational ALU (2-bit op: ADD/SUB/OR/SLT) between NREQ requesters, such as the main datapath, a branch-compare unit and a debug port.
- Grants one request per cycle, round-robin by default.
- Drives the ALU operand and op ports, captures result and zero flag into a one-entry response register.
- Returns the result, tagged with the requester id, over a valid/ready channel.
- Sits between the requesters and the existing ALU instance; contains no arithmetic of its own.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 1, width of the requester id; must equal ceil(log2(NREQ)), minimum 1
DW, 32, operand and result width; must match the ALU

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_data1  in  NREQ*DW  flattened operand A; requester i at [i*DW +: DW]
req_data2  in  NREQ*DW  flattened operand B
req_op  in  NREQ*2  flattened ALU op
alu_data1  out  DW  to ALU data1
alu_data2  out  DW  to ALU data2
alu_op  out  2  to ALU aluop
alu_result  in  DW  from ALU result
alu_zero  in  1  from ALU zero
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_result  out  DW  registered ALU result
rsp_zero  out  1  registered zero flag
rsp_id  out  IDW  index of the requester that issued the op

Behaviour:
- Clock and reset: clk is the only clock. rst is asynchronous and active-high.
- Reset values: rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, rr_ptr=NREQ-1, so requester 0 has first priority.
- FSM, two states:
  - EMPTY: response register holds nothing; rsp_valid=0.
  - FULL: response register holds a result; rsp_valid=1.
- slot_free = (state==EMPTY) | rsp_ready.
- Grant: when slot_free and |req_valid, pick the first valid index scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready[g]=1 combinationally. All other req_ready bits are 0.
  - req_ready is never asserted when slot_free=0.
- A request is consumed on a cycle with req_valid[i] & req_ready[i]. Requesters hold operands and op stable until consumed.
- ALU ports are driven combinationally from the granted requester's operands and op.
  - With no grant: alu_data1=0, alu_data2=0, alu_op=2'b00.
- At the clock edge of a grant:
  - rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=g, rr_ptr<=g.
  - Next state is FULL.
  - Latency is exactly 1 cycle from grant to rsp_valid.
- Transitions:
  - EMPTY & grant -> FULL.
  - FULL & rsp_ready & grant -> FULL, holding the new result. Back-to-back: one op per cycle sustained.
  - FULL & rsp_ready & no grant -> EMPTY.
  - FULL & !rsp_ready -> FULL; the response is held stable and no grant occurs.
- Width rules: result and zero are passed through unmodified. SLT is the ALU's unsigned compare giving 0 or 1. The arbiter performs no masking or extension.
- Simultaneous requests: the round-robin order guarantees each of N continuously valid requesters is granted once every N grants.
- Reset mid-operation: a pending response is discarded, rsp_valid drops immediately (asynchronously), and requests in flight are not granted until rst deasserts.
- rr_ptr is unchanged on cycles with no grant.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins; rr_ptr is removed.
- Undefined: round-robin as above.
- Handshake, latency and FSM are identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - op constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_OR=2'b10, ALU_SLT=2'b11;
  - DW default 32;
  - the FSM state typedef {ST_EMPTY, ST_FULL}.
- Sub-module rr_pick(NREQ): takes req_valid and rr_ptr, outputs one-hot grant and encoded index g. It is purely combinational and reusable by other arbiters.

Test Plan:
- Single requester: req0 data1=5, data2=3, op=SUB, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=2, rsp_zero=0, rsp_id=0.
- Contention: req0 ADD 1+1 and req1 SLT 2<7 both held valid, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; results 2 and 1; one response per cycle.
- Backpressure: FULL with rsp_ready=0 for 3 cycles -> rsp_result and rsp_id stable, req_ready=0; the held request is granted in the cycle rsp_ready rises.
- Zero flag: req1 SUB 0x1234-0x1234 -> rsp_result=0, rsp_zero=1, rsp_id=1; OR 0xF0|0x0F -> 0xFF, rsp_zero=0.
- Reset mid-operation: assert rst while FULL -> rsp_valid=0 immediately, before the next edge; after release, requester 0 is granted first.
- ALU_ARB_FIXED_PRIO_EN defined: req0 and req1 held valid for 4 cycles -> all 4 grants go to req0 and req1 is starved.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU op encodings,
// default datapath width and the response-slot FSM state type.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam int ALU_DW = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// rr_pick: combinational rotating-priority picker. Scans indices
// rr_ptr+1, rr_ptr+2, ... modulo NREQ and returns the first valid one,
// both one-hot (grant) and encoded (g). Holding rr_ptr at NREQ-1 turns it
// into a lowest-index-wins fixed-priority picker.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  g
);

  logic           found;
  logic [IDW-1:0] idx;

  // Walk the rotated order once; the first valid hit wins.
  always_comb begin
    grant = '0;
    g     = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IDW'((int'(rr_ptr) + off) % NREQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        g          = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between NREQ requesters.
// One request is granted per cycle into a one-entry response register,
// returned with the requester id over a valid/ready channel.
// Build option: ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins priority
// instead of round-robin (the rotating pointer is then not built).
//
// Handshakes: a transfer happens on any cycle where valid and ready are
// both high at the rising edge. req_ready is at most one-hot and only rises
// while the response slot is free (empty, or being drained this cycle);
// rsp_valid/rsp_result/rsp_zero/rsp_id are held stable while rsp_ready=0.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1,
  parameter int DW   = ALU_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_data1,
  input  logic [NREQ*DW-1:0]   req_data2,
  input  logic [NREQ*2-1:0]    req_op,
  output logic [DW-1:0]        alu_data1,
  output logic [DW-1:0]        alu_data2,
  output logic [1:0]           alu_op,
  input  logic [DW-1:0]        alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_result,
  output logic                 rsp_zero,
  output logic [IDW-1:0]       rsp_id,
  output state_t               dbg_state
);

  state_t           state, state_nxt;
  logic             slot_free;
  logic [NREQ-1:0]  pick_valid;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   g;
  logic             grant_any;
  logic [IDW-1:0]   rr_ptr;
  logic [DW-1:0]    d1 [NREQ];
  logic [DW-1:0]    d2 [NREQ];
  logic [1:0]       op [NREQ];

  // No grants while reset is held, so in-flight requests wait for release.
  assign slot_free  = (state == ST_EMPTY) | rsp_ready;
  assign pick_valid = req_valid & {NREQ{slot_free & ~rst}};
  assign grant_any  = |grant;
  assign req_ready  = grant;
  assign rsp_valid  = (state == ST_FULL);
  assign dbg_state  = state;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Pointer parked at the last index makes the scan start at requester 0.
  assign rr_ptr = IDW'(NREQ - 1);
`else
  // Rotating pointer remembers the last granted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_ptr <= IDW'(NREQ - 1);
    else if (grant_any) rr_ptr <= g;
  end
`endif

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (pick_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .g         (g)
  );

  // Unflatten the requester buses so the granted slot can be indexed by g.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      d1[i] = req_data1[i*DW +: DW];
      d2[i] = req_data2[i*DW +: DW];
      op[i] = req_op[i*2 +: 2];
    end
  end

  // Drive the ALU from the granted requester, zeros when nothing is granted.
  always_comb begin
    alu_data1 = '0;
    alu_data2 = '0;
    alu_op    = ALU_ADD;
    if (grant_any) begin
      alu_data1 = d1[g];
      alu_data2 = d2[g];
      alu_op    = op[g];
    end
  end

  // Response slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Slot fills on a grant and empties when drained with nothing new behind it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (grant_any) state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !grant_any) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Capture the ALU outputs and the requester id on the grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= '0;
    end else if (grant_any) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_id     <= g;
    end
  end

endmodule
